// File: rtl/divider_unit.sv
// Iterative radix-2 restoring divider (RV64 DIV/DIVU/REM/REMU and *W), start/ok/next handshake.
// Optional DIVIDER_FLAGS_EN adds registered div_dz / div_ovf status outputs.
module divider_unit #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            word,
  input  logic            is_signed,
  input  logic            rem,
  input  logic            next,
  output logic [XLEN-1:0] div_result,
`ifdef DIVIDER_FLAGS_EN
  output logic            div_dz,
  output logic            div_ovf,
`endif
  output logic            div_ok
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){1'b0}}, v};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_last;
  logic [XLEN-1:0] rem_r, quo_r, dvsr;
  logic            word_q, rem_q, q_neg, r_neg;
  logic            load, step, fin, clr;

  logic signed [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] mag_a, mag_b, a_act, spec_res;
  logic            sa, sb, b_zero, ovf, special;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, sel, res_fix;

  // Operand decode for the start edge: active-width extension, signs, magnitudes, special cases
  always_comb begin
    a_act    = word ? sext_word(a[WLEN-1:0]) : a;
    op_a     = word ? signed'(is_signed ? a_act : zext_word(a[WLEN-1:0])) : signed'(a);
    op_b     = word ? signed'(is_signed ? sext_word(b[WLEN-1:0]) : zext_word(b[WLEN-1:0]))
                    : signed'(b);
    sa       = is_signed && (op_a < 0);
    sb       = is_signed && (op_b < 0);
    mag_a    = sa ? -op_a : op_a;
    mag_b    = sb ? -op_b : op_b;
    b_zero   = (op_b == '0);
    ovf      = is_signed && (op_a == signed'(word ? MIN_W : MIN_X)) && (&op_b);
    special  = b_zero || ovf;
    spec_res = b_zero ? (rem ? a_act : '1) : (rem ? '0 : a_act);
  end

  // One restoring step and the final sign fix-up
  always_comb begin
    shifted  = {rem_r, quo_r[XLEN-1]};
    ge       = (shifted >= {1'b0, dvsr});
    rem_step = ge ? (shifted[XLEN-1:0] - dvsr) : shifted[XLEN-1:0];
    quo_step = {quo_r[XLEN-2:0], ge};
    sel      = rem_q ? cond_neg(rem_r, r_neg) : cond_neg(quo_r, q_neg);
    res_fix  = word_q ? sext_word(sel[WLEN-1:0]) : sel;
    cnt_last = word_q ? CW'(WLEN-1) : CW'(XLEN-1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (next) state_n = IDLE;
    else begin
      case (state)
        IDLE: if (div_start) state_n = special ? DONE : ITER;
        ITER: if (!div_start) state_n = IDLE;
              else if (cnt == cnt_last) state_n = FIX;
        FIX:  state_n = div_start ? DONE : IDLE;
        DONE: if (!div_start) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    clr  = 1'b0;
    if (next) clr = 1'b1;
    else begin
      case (state)
        IDLE:    load = div_start;
        ITER:    begin step = div_start; clr = !div_start; end
        FIX:     begin fin  = div_start; clr = !div_start; end
        default: clr = !div_start;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ok     <= 1'b0;
      div_result <= '0;
      cnt        <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvsr       <= '0;
      word_q     <= 1'b0;
      rem_q      <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
`ifdef DIVIDER_FLAGS_EN
      div_dz     <= 1'b0;
      div_ovf    <= 1'b0;
`endif
    end else if (clr) begin
      div_ok     <= 1'b0;
      div_result <= '0;
      cnt        <= '0;
`ifdef DIVIDER_FLAGS_EN
      div_dz     <= 1'b0;
      div_ovf    <= 1'b0;
`endif
    end else if (load) begin
      word_q <= word;
      rem_q  <= rem;
      q_neg  <= sa ^ sb;
      r_neg  <= sa;
      dvsr   <= mag_b;
      rem_r  <= '0;
      // Word mode parks the dividend in the top half so WLEN shifts bring it all through
      quo_r  <= word ? {mag_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : mag_a;
      cnt    <= '0;
      if (special) begin
        div_result <= spec_res;
        div_ok     <= 1'b1;
      end
`ifdef DIVIDER_FLAGS_EN
      div_dz  <= b_zero;
      div_ovf <= ovf && !b_zero;
`endif
    end else if (step) begin
      rem_r <= rem_step;
      quo_r <= quo_step;
      cnt   <= cnt + CW'(1);
    end else if (fin) begin
      div_result <= res_fix;
      div_ok     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Randomised self-checking bench for divider_unit against a plain-arithmetic RISC-V division model.
module tb_divider_unit;

  logic        clk = 1'b0;
  logic        rst_n, div_start, word, is_signed, rem, next;
  logic [63:0] a, b, div_result;
  logic        div_ok;
`ifdef DIVIDER_FLAGS_EN
  logic        div_dz, div_ovf;
`endif

  int errors = 0;
  int checks = 0;

  divider_unit dut (
    .clk(clk), .rst_n(rst_n), .div_start(div_start), .a(a), .b(b),
    .word(word), .is_signed(is_signed), .rem(rem), .next(next),
    .div_result(div_result),
`ifdef DIVIDER_FLAGS_EN
    .div_dz(div_dz), .div_ovf(div_ovf),
`endif
    .div_ok(div_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_dz(input logic [63:0] ta, input logic [63:0] tb_, input bit tw);
    return tw ? (tb_[31:0] == 32'd0) : (tb_ == 64'd0);
  endfunction

  function automatic bit ref_ovf(input logic [63:0] ta, input logic [63:0] tb_, input bit tw, input bit ts);
    if (!ts || ref_dz(ta, tb_, tw)) return 1'b0;
    if (tw) return (ta[31:0] == 32'h8000_0000) && (tb_[31:0] == 32'hFFFF_FFFF);
    return (ta == 64'h8000_0000_0000_0000) && (tb_ == '1);
  endfunction

  function automatic logic [63:0] ref_div(input logic [63:0] ta, input logic [63:0] tb_,
                                          input bit tw, input bit ts, input bit tr);
    logic [31:0] r32;
    int          s32a, s32b;
    longint      s64a, s64b;
    if (tw) begin
      s32a = ta[31:0];
      s32b = tb_[31:0];
      if (ref_dz(ta, tb_, tw))           r32 = tr ? ta[31:0] : 32'hFFFF_FFFF;
      else if (ref_ovf(ta, tb_, tw, ts)) r32 = tr ? 32'd0 : ta[31:0];
      else if (ts)                       r32 = tr ? 32'(s32a % s32b) : 32'(s32a / s32b);
      else                               r32 = tr ? ta[31:0] % tb_[31:0] : ta[31:0] / tb_[31:0];
      return {{32{r32[31]}}, r32};
    end
    s64a = ta;
    s64b = tb_;
    if (ref_dz(ta, tb_, tw))           return tr ? ta : '1;
    if (ref_ovf(ta, tb_, tw, ts))      return tr ? 64'd0 : ta;
    if (ts)                            return tr ? 64'(s64a % s64b) : 64'(s64a / s64b);
    return tr ? ta % tb_ : ta / tb_;
  endfunction

  function automatic int ref_lat(input logic [63:0] ta, input logic [63:0] tb_, input bit tw, input bit ts);
    if (ref_dz(ta, tb_, tw) || ref_ovf(ta, tb_, tw, ts)) return 1;
    return tw ? 34 : 66;
  endfunction

  // rel: 0 = release by dropping div_start, 1 = by next, 2 = leave in DONE with start held
  task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                       input bit tw, input bit ts, input bit tr, input int rel);
    int          k;
    logic [63:0] exp;
    exp = ref_div(ta, tb_, tw, ts, tr);
    @(negedge clk);
    a = ta; b = tb_; word = tw; is_signed = ts; rem = tr; div_start = 1'b1; next = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin a = ~a; b = b ^ 64'h5; end
    end while (!div_ok && k < 200);
    check({tag, " latency"}, 64'(k), 64'(ref_lat(ta, tb_, tw, ts)));
    check({tag, " result"}, div_result, exp);
`ifdef DIVIDER_FLAGS_EN
    check({tag, " dz"}, 64'(div_dz), 64'(ref_dz(ta, tb_, tw)));
    check({tag, " ovf"}, 64'(div_ovf), 64'(ref_ovf(ta, tb_, tw, ts)));
`endif
    if (rel != 2) begin
      @(negedge clk);
      if (rel == 1) next = 1'b1;
      else div_start = 1'b0;
      @(posedge clk); #1;
      check({tag, " ok clear"}, 64'(div_ok), 64'd0);
      @(negedge clk);
      next = 1'b0; div_start = 1'b0;
    end
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (div_ok) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int          k;
    logic [63:0] ra, rb, held;
    rst_n = 1'b0; div_start = 1'b0; next = 1'b0;
    word = 1'b0; is_signed = 1'b0; rem = 1'b0; a = '0; b = '0;
    #12;
    check("reset ok", 64'(div_ok), 64'd0);
    check("reset result", div_result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("t1 q", 64'd100, 64'd7, 0, 1, 0, 0);
    do_op("t1 r", 64'd100, 64'd7, 0, 1, 1, 1);
    do_op("t2 sq", -64'sd7, 64'd2, 0, 1, 0, 0);
    do_op("t2 sr", -64'sd7, 64'd2, 0, 1, 1, 1);
    do_op("t2 uq", 64'h10, 64'd3, 0, 0, 0, 0);
    do_op("t2 ur", 64'h10, 64'd3, 0, 0, 1, 0);
    do_op("t3 wu", 64'h0000_0000_FFFF_FFFF, 64'd1, 1, 0, 0, 0);
    do_op("t3 ws", 64'h1234_0000_0064, 64'hFFFF_FFF6, 1, 1, 0, 1);
    do_op("t4 dzq", 64'h55, 64'd0, 0, 0, 0, 0);
    do_op("t4 dzr", 64'h55, 64'd0, 0, 1, 1, 0);
    do_op("t4 ovq", 64'h8000_0000_0000_0000, '1, 0, 1, 0, 1);
    do_op("t4 ovr", 64'h8000_0000_0000_0000, '1, 0, 1, 1, 0);
    do_op("t4 wov", 64'h8000_0000, 64'hFFFF_FFFF, 1, 1, 0, 0);
    do_op("t4 wdz", 64'hABCD_8000_0001, 64'hFFFF_0000_0000, 1, 0, 1, 0);

    // next mid-ITER cancels, then a fresh operation completes normally
    @(negedge clk);
    a = 64'd1000; b = 64'd3; word = 0; is_signed = 0; rem = 0; div_start = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); next = 1'b1; div_start = 1'b0;
    @(negedge clk); next = 1'b0;
    watch_idle("t5 next cancel", 80);
    do_op("t5 restart", 64'd9, 64'd3, 0, 1, 0, 0);

    // next and div_start together: nothing starts until next drops
    @(negedge clk);
    a = 64'd9; b = 64'd3; word = 0; is_signed = 0; rem = 0; div_start = 1'b1; next = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t5 next prio", 64'(div_ok), 64'd0);
    @(negedge clk); next = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!div_ok && k < 200);
    check("t5 prio latency", 64'(k), 64'd66);
    check("t5 prio result", div_result, 64'd3);
    @(negedge clk); div_start = 1'b0;

    // abort by dropping div_start mid-ITER
    @(negedge clk);
    a = 64'd77; b = 64'd5; div_start = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk); div_start = 1'b0;
    watch_idle("t5 abort", 80);

    // async reset mid-ITER
    @(negedge clk);
    a = 64'd500; b = 64'd9; div_start = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6 rst iter ok", 64'(div_ok), 64'd0);
    check("t6 rst iter res", div_result, 64'd0);
    @(negedge clk); div_start = 1'b0; rst_n = 1'b1;
    watch_idle("t6 rst no result", 70);

    // hold div_start through DONE: stable, no retrigger
    do_op("t6 hold", 64'd12345, 64'd67, 0, 0, 0, 2);
    held = div_result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t6 hold ok", 64'(div_ok), 64'd1);
      check("t6 hold res", div_result, 64'd184);
    end
    check("t6 hold first", held, 64'd184);

    // async reset while DONE is holding a result
    #2 rst_n = 1'b0;
    #1 check("t6 rst done ok", 64'(div_ok), 64'd0);
    check("t6 rst done res", div_result, 64'd0);
    @(negedge clk); div_start = 1'b0; rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       rb = 64'd0;
        1:       rb = '1;
        2:       rb = 64'($urandom_range(1, 300));
        3:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) ra = 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 7) == 0) ra = {$urandom, 32'h8000_0000};
      do_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
